// File: rtl/ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// ram_ctrl_pkg / ram_ctrl_if
//
// Purpose: shared request/response types and the request/response bundle of
//          the rv32i word-organised data RAM controller.
//
// Interface signals:
//   req_valid   master->slave  request present
//   req_ready   slave->master  controller can accept a request (IDLE)
//   addr        master->slave  byte address (upper bits ignored by slave)
//   wdata       master->slave  right-justified store data
//   mem_op      master->slave  MEM_STORE = store, any other value = load
//   ram_mask    master->slave  access size B/H/W (other values act as W)
//   load_signed master->slave  sign-extend B/H loads
//   rsp_valid   slave->master  one-cycle response pulse
//   rdata       slave->master  load result (0 for stores/rejected accesses)
//   misaligned  slave->master  request crossed a word boundary
// ---------------------------------------------------------------------------
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_LOAD  = 2'd0,
    MEM_STORE = 2'd1
  } mem_op_e;

  typedef enum logic [1:0] {
    RAM_MASK_B = 2'd0,
    RAM_MASK_H = 2'd1,
    RAM_MASK_W = 2'd2
  } ram_mask_e;

endpackage

interface ram_ctrl_if;
  import ram_ctrl_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  mem_op_e     mem_op;
  ram_mask_e   ram_mask;
  logic        load_signed;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        misaligned;

  modport master (
    output req_valid, addr, wdata, mem_op, ram_mask, load_signed,
    input  req_ready, rsp_valid, rdata, misaligned
  );

  modport slave (
    input  req_valid, addr, wdata, mem_op, ram_mask, load_signed,
    output req_ready, rsp_valid, rdata, misaligned
  );

endinterface

// File: rtl/ram_ctrl.sv
// ---------------------------------------------------------------------------
// ram_ctrl
//
// Purpose: word-organised data RAM for the rv32i core. 32-bit words with
//          per-byte-lane write enables and a registered read port, so the
//          array maps onto block RAM. One request is outstanding at a time;
//          the FSM walks IDLE -> ACC0 [-> ACC1] -> RSP and emits a one-cycle
//          response pulse. B/H/W loads with optional sign extension.
//
// Ports:
//   clk     in   clock, all logic on the rising edge
//   rst_n   in   synchronous active-low reset
//   bus_if  slave modport of ram_ctrl_if (request/response bundle)
//
// Parameters:
//   ADDR_LENGTH  byte-address bits used; addresses wrap modulo 2**ADDR_LENGTH
//
// Build option:
//   RV32I_RAM_MISALIGN_EN  defined   -> word-crossing accesses are split into
//                                       two beats (ACC0 on word w, ACC1 on w+1)
//                          undefined -> word-crossing accesses are rejected:
//                                       no write, rdata=0, misaligned=1
// ---------------------------------------------------------------------------
module ram_ctrl #(
  parameter int ADDR_LENGTH = 14
) (
  input logic      clk,
  input logic      rst_n,
  ram_ctrl_if.slave bus_if
);
  import ram_ctrl_pkg::*;

  localparam int IW    = ADDR_LENGTH - 2;
  localparam int WORDS = 2 ** IW;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RSP} state_e;

  // Size codes held in size_q
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_e        state_q;
  logic [IW-1:0] word_q;
  logic [1:0]    off_q;
  logic [31:0]   wdata_q;
  logic          store_q;
  logic [1:0]    size_q;
  logic          signed_q;

  logic          rsp_valid_q;
  logic [31:0]   rdata_q;
  logic          misaligned_q;

  logic [31:0]   rd_q;
`ifdef RV32I_RAM_MISALIGN_EN
  logic [31:0]   hold_q;   // word w captured while word w+1 is being read
`endif

  logic [31:0]   mem [WORDS];

  // Only the low ADDR_LENGTH address bits select a location.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus_if.addr[31:ADDR_LENGTH];

  // -------------------------------------------------------------------------
  // Lane bookkeeping. The size mask is shifted by the offset over an 8-lane
  // window: lanes [3:0] belong to word w, lanes [7:4] spill into word w+1.
  // -------------------------------------------------------------------------
  logic [3:0]  size_be;
  logic [7:0]  be_all;
  logic        is_misal;
  logic [63:0] wdata_sh;

  always_comb begin
    size_be = 4'b1111;
    case (size_q)
      SZ_B:    size_be = 4'b0001;
      SZ_H:    size_be = 4'b0011;
      default: size_be = 4'b1111;
    endcase
  end

  assign be_all   = {4'b0000, size_be} << off_q;
  assign is_misal = |be_all[7:4];
  assign wdata_sh = {32'h0, wdata_q} << {off_q, 3'b000};

  logic acc0_we_en;
  logic acc1_we_en;

  // Writes are gated by rst_n so a reset sampled on an access edge
  // suppresses that beat.
`ifdef RV32I_RAM_MISALIGN_EN
  assign acc0_we_en = rst_n && store_q && (state_q == ACC0);
  assign acc1_we_en = rst_n && store_q && (state_q == ACC1);
`else
  assign acc0_we_en = rst_n && store_q && (state_q == ACC0) && !is_misal;
  assign acc1_we_en = 1'b0;
`endif

  logic          mem_en;
  logic [IW-1:0] acc_word;
  logic [3:0]    lane_we;
  logic [31:0]   lane_wd;

  assign mem_en   = (state_q == ACC0) || (state_q == ACC1);
  // Natural IW-bit wrap gives (w+1) mod WORDS.
  assign acc_word = (state_q == ACC1) ? word_q + {{(IW-1){1'b0}}, 1'b1} : word_q;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = (acc0_we_en && be_all[gi]) || (acc1_we_en && be_all[gi+4]);
      assign lane_wd[8*gi +: 8] = (state_q == ACC1) ? wdata_sh[32+8*gi +: 8]
                                                    : wdata_sh[8*gi +: 8];
    end
  endgenerate

  // Byte-enabled write with registered read (old data on same-word access).
  always_ff @(posedge clk) begin
    if (mem_en) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_we[k]) begin
          mem[acc_word][8*k +: 8] <= lane_wd[8*k +: 8];
        end
      end
      rd_q <= mem[acc_word];
    end
  end

  // -------------------------------------------------------------------------
  // Load assembly: bytes from offset o of the (possibly two-word) window,
  // right-justified and extended.
  // -------------------------------------------------------------------------
  logic [63:0] ld_src;
  logic [63:0] ld_sh;
  logic [31:0] load_val;

`ifdef RV32I_RAM_MISALIGN_EN
  assign ld_src = is_misal ? {rd_q, hold_q} : {32'h0, rd_q};
`else
  assign ld_src = {32'h0, rd_q};
`endif
  assign ld_sh = ld_src >> {off_q, 3'b000};

  always_comb begin
    load_val = ld_sh[31:0];
    case (size_q)
      SZ_B:    load_val = {{24{signed_q & ld_sh[7]}},  ld_sh[7:0]};
      SZ_H:    load_val = {{16{signed_q & ld_sh[15]}}, ld_sh[15:0]};
      default: load_val = ld_sh[31:0];
    endcase
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered response outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rsp_valid_q  <= 1'b0;
      rdata_q      <= 32'h0;
      misaligned_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus_if.req_valid) begin
            word_q   <= bus_if.addr[ADDR_LENGTH-1:2];
            off_q    <= bus_if.addr[1:0];
            wdata_q  <= bus_if.wdata;
            store_q  <= (bus_if.mem_op == MEM_STORE);
            signed_q <= bus_if.load_signed;
            case (bus_if.ram_mask)
              RAM_MASK_B: size_q <= SZ_B;
              RAM_MASK_H: size_q <= SZ_H;
              default:    size_q <= SZ_W;
            endcase
            state_q <= ACC0;
          end
        end
        ACC0: begin
`ifdef RV32I_RAM_MISALIGN_EN
          state_q <= is_misal ? ACC1 : RSP;
`else
          state_q <= RSP;
`endif
        end
        ACC1: begin
`ifdef RV32I_RAM_MISALIGN_EN
          hold_q  <= rd_q;
          state_q <= RSP;
`else
          state_q <= IDLE;
`endif
        end
        RSP: begin
          rsp_valid_q  <= 1'b1;
          misaligned_q <= is_misal;
`ifdef RV32I_RAM_MISALIGN_EN
          rdata_q      <= store_q ? 32'h0 : load_val;
`else
          rdata_q      <= (store_q || is_misal) ? 32'h0 : load_val;
`endif
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.req_ready  = (state_q == IDLE);
  assign bus_if.rsp_valid  = rsp_valid_q;
  assign bus_if.rdata      = rdata_q;
  assign bus_if.misaligned = misaligned_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_ctrl
//
// Purpose: directed scoreboard bench for ram_ctrl. Requests push their
//          hand-computed response (rdata, misaligned, arrival cycle) into a
//          queue; an independent negedge monitor pops and checks each
//          rsp_valid pulse. Expected values follow RV32I_RAM_MISALIGN_EN.
// ---------------------------------------------------------------------------
module tb_ram_ctrl;
  import ram_ctrl_pkg::*;

`ifdef RV32I_RAM_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif
  localparam int LA = 2;               // aligned latency
  localparam int LM = MIS_EN ? 3 : 2;  // misaligned latency

  logic clk;
  logic rst_n;
  ram_ctrl_if bus ();

  ram_ctrl #(.ADDR_LENGTH(14)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pos_cnt = 0;
  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        mis;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%h at cycle %0d, required no response",
                 bus.rdata, pos_cnt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.rdata !== e.rdata) begin
          n_bad++;
          $display("FAIL %s.rdata: got %h, required %h", e.name, bus.rdata, e.rdata);
        end
        n_cmp++;
        if (bus.misaligned !== e.mis) begin
          n_bad++;
          $display("FAIL %s.misaligned: got %b, required %b", e.name, bus.misaligned, e.mis);
        end
        n_cmp++;
        if (pos_cnt != e.cyc) begin
          n_bad++;
          $display("FAIL %s.latency: response at cycle %0d, required cycle %0d",
                   e.name, pos_cnt, e.cyc);
        end else begin
          $display("rsp  %-14s rdata=%h misaligned=%b cycle=%0d", e.name, bus.rdata,
                   bus.misaligned, pos_cnt);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Waits (bounded) for req_ready at a negedge; returns 0 on timeout.
  task automatic wait_ready(input string nm, output bit ok);
    int waited;
    waited = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    ok = (bus.req_ready === 1'b1);
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.ready_timeout: got req_ready=%b after 20 cycles, required 1",
               nm, bus.req_ready);
    end
  endtask

  task automatic drive(input mem_op_e op, input ram_mask_e m, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid   = 1'b1;
    bus.mem_op      = op;
    bus.ram_mask    = m;
    bus.load_signed = sg;
    bus.addr        = a;
    bus.wdata       = wd;
  endtask

  task automatic do_req(input string nm, input mem_op_e op, input ram_mask_e m,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic em, input int lat);
    bit   ok;
    exp_t e;
    wait_ready(nm, ok);
    if (ok) begin
      drive(op, m, sg, a, wd);
      e.name  = nm;
      e.rdata = er;
      e.mis   = em;
      e.cyc   = pos_cnt + 1 + lat;
      exp_q.push_back(e);
      $display("req  %-14s op=%0d mask=%0d sgn=%b addr=%h wdata=%h", nm, op, m, sg, a, wd);
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
  endtask

  initial begin
    bit   ok;
    exp_t e;
    int   p;
    int   waited;

    bus.req_valid   = 1'b0;
    bus.addr        = 32'h0;
    bus.wdata       = 32'h0;
    bus.mem_op      = MEM_LOAD;
    bus.ram_mask    = RAM_MASK_W;
    bus.load_signed = 1'b0;
    rst_n           = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset.req_ready",  {31'h0, bus.req_ready},  32'h1);
    chk("reset.rsp_valid",  {31'h0, bus.rsp_valid},  32'h0);
    chk("reset.rdata",      bus.rdata,               32'h0);
    chk("reset.misaligned", {31'h0, bus.misaligned}, 32'h0);

    // Word store/load and sub-word loads
    do_req("st_w_10",   MEM_STORE, RAM_MASK_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, LA);
    do_req("st_w_14",   MEM_STORE, RAM_MASK_W, 1'b0, 32'h14, 32'h12345678, 32'h0,        1'b0, LA);
    do_req("ld_w_10",   MEM_LOAD,  RAM_MASK_W, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, LA);
    do_req("ld_bs_13",  MEM_LOAD,  RAM_MASK_B, 1'b1, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, LA);
    do_req("ld_bu_13",  MEM_LOAD,  RAM_MASK_B, 1'b0, 32'h13, 32'h0,        32'h000000DE, 1'b0, LA);
    do_req("ld_hu_12",  MEM_LOAD,  RAM_MASK_H, 1'b0, 32'h12, 32'h0,        32'h0000DEAD, 1'b0, LA);
    do_req("ld_hs_10",  MEM_LOAD,  RAM_MASK_H, 1'b1, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0, LA);
    // Byte store only touches its lane; neighbour word untouched
    do_req("st_b_11",   MEM_STORE, RAM_MASK_B, 1'b0, 32'h11, 32'hAAAAAA55, 32'h0,        1'b0, LA);
    do_req("ld_w_10b",  MEM_LOAD,  RAM_MASK_W, 1'b0, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0, LA);
    do_req("ld_w_14",   MEM_LOAD,  RAM_MASK_W, 1'b0, 32'h14, 32'h0,        32'h12345678, 1'b0, LA);

    // Misaligned word store across 0x1C/0x20
    do_req("st_w_1c",   MEM_STORE, RAM_MASK_W, 1'b0, 32'h1C, 32'hA0A1A2A3, 32'h0,        1'b0, LA);
    do_req("st_w_20",   MEM_STORE, RAM_MASK_W, 1'b0, 32'h20, 32'hB0B1B2B3, 32'h0,        1'b0, LA);
    do_req("st_w_1e",   MEM_STORE, RAM_MASK_W, 1'b0, 32'h1E, 32'h11223344, 32'h0,        1'b1, LM);
    do_req("ld_w_1e",   MEM_LOAD,  RAM_MASK_W, 1'b0, 32'h1E, 32'h0,
           MIS_EN ? 32'h11223344 : 32'h0, 1'b1, LM);
    do_req("ld_w_1c",   MEM_LOAD,  RAM_MASK_W, 1'b0, 32'h1C, 32'h0,
           MIS_EN ? 32'h3344A2A3 : 32'hA0A1A2A3, 1'b0, LA);
    do_req("ld_w_20",   MEM_LOAD,  RAM_MASK_W, 1'b0, 32'h20, 32'h0,
           MIS_EN ? 32'hB0B11122 : 32'hB0B1B2B3, 1'b0, LA);
    // o+n == 4 is still aligned; o+n == 5 is not
    do_req("ld_hs_1e",  MEM_LOAD,  RAM_MASK_H, 1'b1, 32'h1E, 32'h0,
           MIS_EN ? 32'h00003344 : 32'hFFFFA0A1, 1'b0, LA);
    do_req("ld_hu_1f",  MEM_LOAD,  RAM_MASK_H, 1'b0, 32'h1F, 32'h0,
           MIS_EN ? 32'h00002233 : 32'h0, 1'b1, LM);

    // Address wrap: top word and word 0, upper address bits ignored
    do_req("st_w_3ffc", MEM_STORE, RAM_MASK_W, 1'b0, 32'h3FFC,     32'hC0C1C2C3, 32'h0, 1'b0, LA);
    do_req("st_w_0",    MEM_STORE, RAM_MASK_W, 1'b0, 32'h0,        32'hD0D1D2D3, 32'h0, 1'b0, LA);
    do_req("st_w_wrap", MEM_STORE, RAM_MASK_W, 1'b0, 32'h0001_3FFE, 32'h55667788, 32'h0, 1'b1, LM);
    do_req("ld_w_wrap", MEM_LOAD,  RAM_MASK_W, 1'b0, 32'h3FFE, 32'h0,
           MIS_EN ? 32'h55667788 : 32'h0, 1'b1, LM);
    do_req("ld_w_3ffc", MEM_LOAD,  RAM_MASK_W, 1'b0, 32'h3FFC, 32'h0,
           MIS_EN ? 32'h7788C2C3 : 32'hC0C1C2C3, 1'b0, LA);
    do_req("ld_w_0",    MEM_LOAD,  RAM_MASK_W, 1'b0, 32'hFFFF_C000, 32'h0,
           MIS_EN ? 32'hD0D15566 : 32'hD0D1D2D3, 1'b0, LA);

    // req_valid held high: ready drops during ACC0/RSP, second request
    // is accepted as soon as the controller is back in IDLE.
    wait_ready("b2b", ok);
    if (ok) begin
      p = pos_cnt;
      drive(MEM_LOAD, RAM_MASK_W, 1'b0, 32'h10, 32'h0);
      e.name = "b2b_first";  e.rdata = 32'hDEAD55EF; e.mis = 1'b0; e.cyc = p + 3;
      exp_q.push_back(e);
      e.name = "b2b_second"; e.rdata = 32'hDEAD55EF; e.mis = 1'b0; e.cyc = p + 6;
      exp_q.push_back(e);
      $display("req  b2b            load W @00000010 with req_valid held");
      @(negedge clk);
      chk("b2b.ready_acc0", {31'h0, bus.req_ready}, 32'h0);
      @(negedge clk);
      chk("b2b.ready_rsp",  {31'h0, bus.req_ready}, 32'h0);
      @(negedge clk);
      chk("b2b.ready_idle", {31'h0, bus.req_ready}, 32'h1);
      @(negedge clk);
      chk("b2b.ready_acc0b", {31'h0, bus.req_ready}, 32'h0);
      bus.req_valid = 1'b0;
    end

    // Reset during the ACC0 beat of a misaligned store
    wait_ready("rst_mid", ok);
    if (ok) begin
      drive(MEM_STORE, RAM_MASK_W, 1'b0, 32'h1E, 32'hEEEEEEEE);
      $display("req  rst_mid        store W @0000001e, reset during ACC0");
      @(negedge clk);
      bus.req_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid.req_ready",  {31'h0, bus.req_ready},  32'h1);
      chk("rst_mid.rsp_valid",  {31'h0, bus.rsp_valid},  32'h0);
      chk("rst_mid.rdata",      bus.rdata,               32'h0);
      chk("rst_mid.misaligned", {31'h0, bus.misaligned}, 32'h0);
    end
    do_req("ld_w_20_rst", MEM_LOAD, RAM_MASK_W, 1'b0, 32'h20, 32'h0,
           MIS_EN ? 32'hB0B11122 : 32'hB0B1B2B3, 1'b0, LA);

    // Drain outstanding responses
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
